// File: rtl/keypad_digit_scanner.sv
// keypad_digit_scanner: scans a 4x4 active-low keypad, debounces full-scan snapshots
// and emits one digit, strobe and stretched step pulse per accepted press.
module keypad_digit_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int PULSE_WIDTH    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] colDrive,
    input  logic [3:0] rowSense,
    output logic [3:0] digit,
    output logic       digitValid,
    output logic       stepPulse,
    output logic       keyHeld,
    output logic       multiKey
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PW = $clog2(PULSE_WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_CANDIDATE, S_PRESSED, S_RELEASE} state_t;
    logic [3:0]    r_row_meta, r_row_sync;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [15:0]   r_snap;
    logic          r_scan_done;
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_cand, w_cand, r_digit;
    logic          r_valid, r_multi, w_accept, w_sample;
    logic [PW-1:0] r_pulse;
    logic [4:0]    w_ones;
    logic [3:0]    w_code;
    assign w_sample   = r_slot == SW'(SCAN_DIV - 1);
    assign colDrive   = ~(4'b0001 << r_col);
    assign digit      = r_digit;
    assign digitValid = r_valid;
    assign stepPulse  = r_pulse != '0;
    assign keyHeld    = r_state == S_PRESSED || r_state == S_RELEASE;
    assign multiKey   = r_multi;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_row_meta  <= 4'hF;
            r_row_sync  <= 4'hF;
            r_slot      <= '0;
            r_col       <= '0;
            r_snap      <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_row_meta  <= rowSense;
            r_row_sync  <= r_row_meta;
            r_slot      <= w_sample ? '0 : r_slot + 1'b1;
            r_col       <= r_col + 2'(w_sample);
            r_scan_done <= w_sample && r_col == 2'd3;
            if (w_sample)
                for (int r = 0; r < 4; r++)
                    r_snap[{2'(r), r_col}] <= ~r_row_sync[r];
        end
    end
    // Classification: a single key reports its code; with more keys the code is unused.
    always_comb begin
        w_ones = '0;
        w_code = '0;
        for (int i = 0; i < 16; i++)
            if (r_snap[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = 4'(i);
            end
    end
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_cand   = r_cand;
        w_accept = 1'b0;
        if (r_scan_done)
            case (r_state)
                S_IDLE:
                    if (w_ones == 5'd1) begin
                        w_state = S_CANDIDATE;
                        w_cand  = w_code;
                        w_cnt   = CW'(1);
                    end
                S_CANDIDATE:
                    if (w_ones == 5'd1 && w_code == r_cand) begin
                        if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            w_state  = S_PRESSED;
                            w_accept = 1'b1;
                            w_cnt    = '0;
                        end else
                            w_cnt = r_cnt + 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_cnt   = '0;
                    end
                S_PRESSED:
                    if (w_ones == '0) begin
                        w_state = S_RELEASE;
                        w_cnt   = CW'(1);
                    end
                S_RELEASE:
                    if (w_ones != '0) begin
                        w_state = S_PRESSED;
                        w_cnt   = '0;
                    end else if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                        w_state = S_IDLE;
                        w_cnt   = '0;
                    end else
                        w_cnt = r_cnt + 1'b1;
                default: w_state = S_IDLE;
            endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_digit <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cand  <= w_cand;
            r_digit <= w_accept ? r_cand : r_digit;
            r_valid <= w_accept;
            r_multi <= r_scan_done ? w_ones > 5'd1 : r_multi;
            r_pulse <= w_accept ? PW'(PULSE_WIDTH) : (r_pulse != '0 ? r_pulse - 1'b1 : '0);
        end
    end
endmodule

// File: tb/tb_keypad_digit_scanner.sv
// tb_keypad_digit_scanner: directed scenarios with a physical keypad model and
// hand-computed event cycles (one scan = 16 cycles).
module tb_keypad_digit_scanner;
    logic        CLK, RST;
    logic [3:0]  colDrive, rowSense, digit;
    logic        digitValid, stepPulse, keyHeld, multiKey;
    logic [15:0] keys;
    int errors, checks;
    int cyc, dv_cnt, dv_cyc, dv_digit, sp_cnt, sp_first, kh_rise, kh_fall, mk_first;
    logic kh_prev;

    keypad_digit_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .PULSE_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .colDrive(colDrive), .rowSense(rowSense), .digit(digit),
        .digitValid(digitValid), .stepPulse(stepPulse), .keyHeld(keyHeld), .multiKey(multiKey)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A closed key at row r, column c pulls row r low while column c is driven low.
    always_comb
        for (int r = 0; r < 4; r++)
            rowSense[r] = ~|(keys[4*r +: 4] & ~colDrive);

    task automatic step;
        @(negedge CLK);
        cyc++;
        if (digitValid) begin
            dv_cnt++;
            dv_cyc = cyc;
            dv_digit = int'(digit);
        end
        if (stepPulse) begin
            sp_cnt++;
            if (sp_first < 0) sp_first = cyc;
        end
        if (keyHeld && !kh_prev && kh_rise < 0) kh_rise = cyc;
        if (!keyHeld && kh_prev && kh_fall < 0) kh_fall = cyc;
        kh_prev = keyHeld;
        if (multiKey && mk_first < 0) mk_first = cyc;
    endtask

    task automatic clear_stats;
        cyc = 0; dv_cnt = 0; dv_cyc = -1; dv_digit = -1; sp_cnt = 0; sp_first = -1;
        kh_rise = -1; kh_fall = -1; mk_first = -1; kh_prev = keyHeld;
    endtask

    task automatic align;
        logic [3:0] p;
        p = colDrive;
        for (int i = 0; i < 40; i++) begin
            step;
            if (p == 4'b0111 && colDrive == 4'b1110) begin
                clear_stats;
                return;
            end
            p = colDrive;
        end
        checks++; errors++;
        $display("FAIL align: no scan start within 40 cycles, colDrive=%b", colDrive);
        clear_stats;
    endtask

    task automatic run(input logic [15:0] k, input int n);
        keys = k;
        repeat (n * 16) step;
    endtask

    task automatic test_reset;
        logic [3:0] e;
        RST = 1'b0; keys = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (colDrive !== 4'b1110) begin errors++; $display("FAIL rst_col got %b want 1110", colDrive); end
        checks++;
        if ({digit, digitValid, stepPulse, keyHeld, multiKey} !== 8'h00) begin
            errors++; $display("FAIL rst_outs got %h want 00", {digit, digitValid, stepPulse, keyHeld, multiKey});
        end
        RST = 1'b1;
        clear_stats;
        for (int i = 1; i <= 12; i++) begin
            step;
            e = ~(4'b0001 << (i / 4));
            checks++;
            if (colDrive !== e) begin errors++; $display("FAIL rotate cyc=%0d got %b want %b", i, colDrive, e); end
        end
    endtask

    task automatic test_single_press;
        align;
        run(16'h0040, 6);
        run(16'h0000, 4);
        checks++;
        if (dv_cnt !== 1) begin errors++; $display("FAIL t2_dv_count got %0d want 1", dv_cnt); end
        checks++;
        if (dv_digit !== 6) begin errors++; $display("FAIL t2_digit got %0d want 6", dv_digit); end
        checks++;
        if (dv_cyc !== 49) begin errors++; $display("FAIL t2_dv_cycle got %0d want 49", dv_cyc); end
        checks++;
        if (sp_cnt !== 2 || sp_first !== 49) begin
            errors++; $display("FAIL t2_pulse got len=%0d start=%0d want len=2 start=49", sp_cnt, sp_first);
        end
        checks++;
        if (kh_rise !== 49 || kh_fall !== 145) begin
            errors++; $display("FAIL t2_held got rise=%0d fall=%0d want 49/145", kh_rise, kh_fall);
        end
        checks++;
        if (digit !== 4'd6) begin errors++; $display("FAIL t2_digit_hold got %0d want 6", digit); end
    endtask

    task automatic test_bounce;
        align;
        run(16'h0200, 2);
        run(16'h0000, 1);
        run(16'h0200, 3);
        checks++;
        if (dv_cnt !== 0) begin errors++; $display("FAIL t3_early got %0d strobes want 0", dv_cnt); end
        run(16'h0000, 3);
        checks++;
        if (dv_cnt !== 1 || dv_digit !== 9) begin
            errors++; $display("FAIL t3_strobe got cnt=%0d digit=%0d want 1/9", dv_cnt, dv_digit);
        end
        checks++;
        if (dv_cyc !== 97) begin errors++; $display("FAIL t3_dv_cycle got %0d want 97", dv_cyc); end
    endtask

    task automatic test_multi_key;
        align;
        run(16'h0003, 5);
        checks++;
        if (mk_first !== 17) begin errors++; $display("FAIL t4_mk_first got %0d want 17", mk_first); end
        checks++;
        if (multiKey !== 1'b1) begin errors++; $display("FAIL t4_mk_level got %b want 1", multiKey); end
        checks++;
        if (dv_cnt !== 0 || keyHeld !== 1'b0) begin
            errors++; $display("FAIL t4_idle got strobes=%0d held=%b want 0/0", dv_cnt, keyHeld);
        end
        run(16'h0000, 2);
        checks++;
        if (multiKey !== 1'b0) begin errors++; $display("FAIL t4_mk_clear got %b want 0", multiKey); end
    endtask

    task automatic test_release_glitch;
        align;
        run(16'h0200, 3);
        run(16'h0000, 1);
        run(16'h0200, 1);
        run(16'h0000, 3);
        run(16'h0001, 3);
        run(16'h0000, 4);
        checks++;
        if (dv_cnt !== 2) begin errors++; $display("FAIL t5_dv_count got %0d want 2", dv_cnt); end
        checks++;
        if (dv_digit !== 0 || dv_cyc !== 177) begin
            errors++; $display("FAIL t5_second got digit=%0d cyc=%0d want 0/177", dv_digit, dv_cyc);
        end
        checks++;
        if (kh_fall !== 129) begin errors++; $display("FAIL t5_held_fall got %0d want 129", kh_fall); end
    endtask

    task automatic test_reset_mid;
        align;
        run(16'h0020, 2);
        checks++;
        if (dv_cnt !== 0) begin errors++; $display("FAIL t6_pre got %0d strobes want 0", dv_cnt); end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (colDrive !== 4'b1110 || {digit, digitValid, stepPulse, keyHeld, multiKey} !== 8'h00) begin
            errors++; $display("FAIL t6_async got col=%b outs=%h want 1110/00", colDrive,
                               {digit, digitValid, stepPulse, keyHeld, multiKey});
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        clear_stats;
        run(16'h0020, 4);
        checks++;
        if (dv_cnt !== 1 || dv_cyc !== 49) begin
            errors++; $display("FAIL t6_fresh got cnt=%0d cyc=%0d want 1/49", dv_cnt, dv_cyc);
        end
        checks++;
        if (dv_digit !== 5) begin errors++; $display("FAIL t6_digit got %0d want 5", dv_digit); end
    endtask

    initial begin
        errors = 0; checks = 0; keys = '0; RST = 1'b0;
        clear_stats;
        test_reset;
        test_single_press;
        test_bounce;
        test_multi_key;
        test_release_glitch;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_digit_scanner.md
Name: keypad_digit_scanner

Overview:
- Upstream front end of the serial password lock.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and resolves one key to a 4-bit code.
- Each accepted keypress produces exactly one digit plus a single-cycle strobe and a stretched step pulse; these feed the lock's digit input and its entry-advance logic.
- Multi-key presses and contact bounce are rejected here so the lock sees at most one digit per physical press.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven; rows are sampled on the last cycle of the slot. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan snapshots required to accept a press, and to accept a release. Must be >= 2.
- PULSE_WIDTH, 8: length of stepPulse in cycles. Must be >= 1 and < DEBOUNCE_SCANS*4*SCAN_DIV.

Ports:
- CLK  input  1  system clock; sole clock.
- RST  input  1  asynchronous, active-low reset.
- colDrive  output  4  column drive, active-low, exactly one bit low at any time.
- rowSense  input  4  row returns, active-low, pulled up, asynchronous to CLK.
- digit  output  4  code of last accepted key; holds between presses.
- digitValid  output  1  one-cycle strobe when a key is accepted.
- stepPulse  output  1  stretched accept pulse, PULSE_WIDTH cycles.
- keyHeld  output  1  high from accept until release is accepted.
- multiKey  output  1  high while the latest snapshot has more than one key down.

Behaviour:
- Clocking and reset: one clock CLK; reset RST is asynchronous and active-low. All state clears immediately on RST low.
- Reset values:
  - colDrive = 4'b1110 (column 0 driven).
  - digit = 0, digitValid = 0, stepPulse = 0, keyHeld = 0, multiKey = 0.
  - FSM in S_IDLE; slot, column and debounce counters = 0.
- Input sync: rowSense passes through a 2-FF synchroniser before any use.
- Scan:
  - Slot counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1: the inverted synchronised rows are stored into snapshot bits [4*r + c] for current column c, then the column advances c -> (c+1) mod 4.
  - colDrive changes on the cycle after the sample.
  - Sampling column 3 completes a snapshot and raises an internal scanDone for one cycle.
- Key code: row r, column c -> 4*r + c, range 0..15.
- Snapshot classification, evaluated only on scanDone:
  - none = zero keys down.
  - single(k) = exactly one key down, code k.
  - multi = two or more keys down.
  - multiKey is registered on each scanDone and equals (class == multi).
- FSM, transitions only on scanDone:
  - S_IDLE:
    - single(k) -> S_CANDIDATE; candidate = k, count = 1.
    - none or multi -> stay.
  - S_CANDIDATE:
    - single(candidate) -> count+1. When count reaches DEBOUNCE_SCANS: go to S_PRESSED, digit <= candidate, digitValid = 1 for the next cycle only, stepPulse starts, keyHeld = 1.
    - Any other class -> S_IDLE, count = 0, no output.
  - S_PRESSED:
    - none -> S_RELEASE, count = 1.
    - Otherwise stay. There is no auto-repeat; a different key pressed while held is ignored.
  - S_RELEASE:
    - none -> count+1. When count reaches DEBOUNCE_SCANS: go to S_IDLE, keyHeld = 0.
    - Any nonzero snapshot -> S_PRESSED, no new strobe.
- Latency: digitValid asserts on the cycle after the scanDone that completes the DEBOUNCE_SCANS-th matching snapshot. digit is valid on that same cycle.
- stepPulse: high for exactly PULSE_WIDTH cycles, starting with digitValid. A new accept cannot occur before it ends, by the parameter constraint.
- Timing: the release check requires at least DEBOUNCE_SCANS scans, so the minimum interval between two strobes is 2*DEBOUNCE_SCANS full scans.
- Reset mid-operation: any partial candidate, release count or pulse is discarded, and no strobe is produced on reset exit.

Test Plan:
Parameters for all tests: SCAN_DIV=4, DEBOUNCE_SCANS=3, PULSE_WIDTH=2, so one scan = 16 cycles.
1. Reset -> during and after RST low: colDrive=1110, all outputs 0. After release of RST, colDrive rotates 1110 -> 1101 -> 1011 -> 0111 every 4 cycles.
2. Hold row1/col2 for 6 scans, then release for 4 scans -> exactly one digitValid, with digit=6. stepPulse high for 2 cycles from the strobe. keyHeld rises with the strobe and falls after the 3rd empty scan.
3. Bounce: row2/col1 present for 2 scans, absent 1 scan, present 3 scans -> a single strobe with digit=9, only after the 3rd consecutive present scan.
4. row0/col0 and row0/col1 held together for 5 scans -> multiKey=1 from the first scanDone, no digitValid, FSM stays in S_IDLE.
5. Release glitch: press 9, release 1 scan, re-close 1 scan, release 3 scans, then press row0/col0 -> no second strobe for 9; the next strobe has digit=0.
6. Assert RST during S_CANDIDATE (count=2) -> outputs cleared, and a key held continuously through the reset produces a strobe only after 3 fresh scans.
